// File: rtl/wb_pkg.sv
// Types and constants shared by the Wishbone burst reader and its testbench:
// the reader FSM states and the Wishbone cycle-type (cti) encodings.
package wb_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_ROOM = 2'd1,
        BURST     = 2'd2
    } state_t;

    localparam logic [2:0] CLASSIC = 3'b000;
    localparam logic [2:0] INCR    = 3'b010;
    localparam logic [2:0] EOB     = 3'b111;

endpackage

// File: rtl/wshb_if.sv
// Wishbone B4 registered-feedback bus: 32-bit data, byte address, cti/bte burst tags.
interface wshb_if;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat_ms;
    logic [31:0] dat_sm;
    logic        ack;
    logic [2:0]  cti;
    logic [1:0]  bte;

    modport master (
        output cyc, stb, we, sel, adr, dat_ms, cti, bte,
        input  dat_sm, ack
    );

    modport slave (
        input  cyc, stb, we, sel, adr, dat_ms, cti, bte,
        output dat_sm, ack
    );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO: rd_data always presents the oldest word, so a
// word written on one edge is visible on the next cycle with no extra read stage.
module sync_fifo #(
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 32,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty,
    output logic [AW:0]       count
);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr_reg;
    logic [AW-1:0]     rd_ptr_reg;
    logic [AW:0]       count_reg;
    logic              push;
    logic              pop;

    assign empty = (count_reg == '0);
    assign full  = (count_reg == (AW+1)'(DEPTH));
    assign count = count_reg;
    assign pop   = rd_en && !empty;
    // A pop frees a slot in the same edge, so a full FIFO may still accept a push.
    assign push  = wr_en && (!full || pop);

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr_reg] <= wr_data;
    end

    assign rd_data = mem[rd_ptr_reg];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push)
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            case ({push, pop})
                2'b10:   count_reg <= count_reg + (AW+1)'(1);
                2'b01:   count_reg <= count_reg - (AW+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end
endmodule

// File: rtl/wb_burst_reader.sv
// Reads nb_words consecutive 32-bit words over Wishbone incrementing bursts and
// streams them out through a FIFO; a burst is only launched once it fits entirely.
module wb_burst_reader
    import wb_pkg::*;
#(
    parameter int BURST_LEN  = 16,
    parameter int CNT_W      = 16,
    parameter int FIFO_DEPTH = 2 * BURST_LEN
) (
    input  logic             clk,
    input  logic             rst,
    wshb_if.master           wb_m,
    input  logic             start,
    input  logic [31:0]      base_adr,
    input  logic [CNT_W-1:0] nb_words,
    output logic             busy,
    output logic             done,
    output logic [31:0]      dout,
    output logic             dout_valid,
    input  logic             dout_ready
);
    localparam int BW = $clog2(BURST_LEN) + 1;
    localparam int FW = $clog2(FIFO_DEPTH) + 1;

    state_t           state_reg;
    logic [31:0]      adr_reg;
    logic [CNT_W-1:0] remaining_reg;
    logic [BW-1:0]    beat_reg;
    logic             cyc_reg;
    logic [2:0]       cti_reg;
    logic             busy_reg;
    logic             done_reg;

    logic [CNT_W-1:0] beats;
    logic             room_ok;
    logic [FW-1:0]    fifo_count;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;

    assign beats   = (remaining_reg > CNT_W'(BURST_LEN)) ? CNT_W'(BURST_LEN) : remaining_reg;
    assign room_ok = !fifo_full &&
                     ((32'(FIFO_DEPTH) - 32'(fifo_count)) >= 32'(beats));
    // stb equals cyc here, so gating with cyc_reg drops acks outside a burst.
    assign push    = cyc_reg && wb_m.ack;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            adr_reg       <= '0;
            remaining_reg <= '0;
            beat_reg      <= '0;
            cyc_reg       <= 1'b0;
            cti_reg       <= CLASSIC;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            unique case (state_reg)
                IDLE: begin
                    if (start) begin
                        if (nb_words == '0) begin
                            done_reg <= 1'b1;
                        end else begin
                            adr_reg       <= base_adr;
                            remaining_reg <= nb_words;
                            busy_reg      <= 1'b1;
                            state_reg     <= WAIT_ROOM;
                        end
                    end
                end
                WAIT_ROOM: begin
                    if (room_ok) begin
                        state_reg <= BURST;
                        cyc_reg   <= 1'b1;
                        beat_reg  <= BW'(beats);
                        cti_reg   <= (beats == CNT_W'(1)) ? EOB : INCR;
                    end
                end
                BURST: begin
                    if (wb_m.ack) begin
                        adr_reg       <= adr_reg + 32'd4;
                        remaining_reg <= remaining_reg - CNT_W'(1);
                        beat_reg      <= beat_reg - BW'(1);
                        // Tag the upcoming beat as end-of-burst one ack ahead.
                        if (beat_reg == BW'(2))
                            cti_reg <= EOB;
                        if (beat_reg == BW'(1)) begin
                            cyc_reg <= 1'b0;
                            cti_reg <= CLASSIC;
                            if (remaining_reg == CNT_W'(1)) begin
                                state_reg <= IDLE;
                                busy_reg  <= 1'b0;
                                done_reg  <= 1'b1;
                            end else begin
                                state_reg <= WAIT_ROOM;
                            end
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign wb_m.cyc    = cyc_reg;
    assign wb_m.stb    = cyc_reg;
    assign wb_m.we     = 1'b0;
    assign wb_m.sel    = 4'hF;
    assign wb_m.bte    = 2'b00;
    assign wb_m.dat_ms = '0;
    assign wb_m.adr    = adr_reg;
    assign wb_m.cti    = cti_reg;

    assign busy       = busy_reg;
    assign done       = done_reg;
    assign dout_valid = !fifo_empty;

    sync_fifo #(
        .DATA_W (32),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push),
        .wr_data (wb_m.dat_sm),
        .rd_en   (dout_ready),
        .rd_data (dout),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );
endmodule

// File: tb/tb_wb_burst_reader.sv
// Self-checking bench for wb_burst_reader: randomly stalling Wishbone slave whose
// word at byte address A is A>>2, random consumer, and a queue-based reference model.
module tb_wb_burst_reader;
    import wb_pkg::*;

    localparam int BURST_LEN  = 16;
    localparam int CNT_W      = 16;
    localparam int FIFO_DEPTH = 32;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [31:0]      base_adr = '0;
    logic [CNT_W-1:0] nb_words = '0;
    logic             busy;
    logic             done;
    logic [31:0]      dout;
    logic             dout_valid;
    logic             dout_ready = 1'b0;

    always #5 clk = ~clk;

    wshb_if wb();

    wb_burst_reader #(
        .BURST_LEN  (BURST_LEN),
        .CNT_W      (CNT_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wb_m       (wb.master),
        .start      (start),
        .base_adr   (base_adr),
        .nb_words   (nb_words),
        .busy       (busy),
        .done       (done),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready)
    );

    int errors = 0;
    int checks = 0;
    int bursts = 0;
    int dones  = 0;
    int ready_mode = 0;   // 0 random, 1 held low, 2 held high
    logic cyc_prev = 1'b0;

    logic [31:0] exp_adr[$];
    logic [2:0]  exp_cti[$];
    logic [31:0] exp_data[$];

    typedef struct {
        logic [31:0] base;
        int          n;
        int          nbursts;
    } vec_t;

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
        end
    endtask

    task automatic flag_fail(string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    // Reference model: word k of a transfer sits at base+4k (mod 2^32); bursts
    // are consecutive BURST_LEN-sized chunks, each ending on an EOB beat.
    task automatic expect_xfer(logic [31:0] b, int n);
        logic [31:0] a;
        for (int k = 0; k < n; k++) begin
            a = b + 32'(4 * k);
            exp_adr.push_back(a);
            exp_data.push_back({2'b00, a[31:2]});
            exp_cti.push_back(((k % BURST_LEN) == BURST_LEN - 1 || k == n - 1) ? EOB : INCR);
        end
    endtask

    // Slave and consumer drive just after the active edge.
    always @(posedge clk) begin
        #1;
        if (wb.cyc && wb.stb) begin
            wb.ack    = ($urandom_range(0, 3) != 0);
            wb.dat_sm = {2'b00, wb.adr[31:2]};
        end else begin
            wb.ack    = ($urandom_range(0, 7) == 0);
            wb.dat_sm = 32'hDEADBEEF;
        end
        case (ready_mode)
            0:       dout_ready = 1'($urandom_range(0, 1));
            1:       dout_ready = 1'b0;
            default: dout_ready = 1'b1;
        endcase
    end

    // Monitor samples on the falling edge, between active edges.
    always @(negedge clk) begin
        if (rst) begin
            cyc_prev = 1'b0;
        end else begin
            if (wb.cyc && !cyc_prev)
                bursts++;
            cyc_prev = wb.cyc;
            if (done)
                dones++;
            if (wb.cyc && wb.stb && wb.ack) begin
                if (exp_adr.size() == 0) begin
                    flag_fail("unexpected_beat");
                end else begin
                    check("beat_adr", wb.adr, exp_adr.pop_front());
                    check("beat_cti", {29'b0, wb.cti}, {29'b0, exp_cti.pop_front()});
                    check("beat_ctl", {wb.we, wb.sel, wb.bte}, {1'b0, 4'hF, 2'b00});
                end
            end
            if (dout_valid && dout_ready) begin
                if (exp_data.size() == 0)
                    flag_fail("unexpected_dout");
                else
                    check("dout", dout, exp_data.pop_front());
            end
        end
    end

    task automatic pulse_start(logic [31:0] b, int n);
        @(posedge clk); #1;
        start    = 1'b1;
        base_adr = b;
        nb_words = CNT_W'(n);
        @(posedge clk); #1;
        start    = 1'b0;
    endtask

    task automatic wait_done(string name);
        int c = 0;
        while (dones == 0 && c < 3000) begin
            @(posedge clk);
            c++;
        end
        if (dones == 0)
            flag_fail({name, "_done_timeout"});
    endtask

    task automatic wait_drain(string name);
        int c = 0;
        while (exp_data.size() != 0 && c < 3000) begin
            @(posedge clk);
            c++;
        end
        if (exp_data.size() != 0)
            flag_fail({name, "_drain_timeout"});
        @(negedge clk);
    endtask

    task automatic run_xfer(string name, logic [31:0] b, int n, int nbursts);
        bursts = 0;
        dones  = 0;
        expect_xfer(b, n);
        pulse_start(b, n);
        wait_done(name);
        wait_drain(name);
        repeat (3) @(negedge clk);
        check({name, "_bursts"}, 32'(bursts), 32'(nbursts));
        check({name, "_dones"}, 32'(dones), 32'd1);
        check({name, "_beats_left"}, 32'(exp_adr.size()), 32'd0);
        check({name, "_idle"}, {30'b0, busy, dout_valid}, 32'd0);
        $display("xfer %s base=0x%08h n=%0d bursts=%0d", name, b, n, bursts);
    endtask

    vec_t vecs[8];

    initial begin
        vecs[0] = '{32'h0000_0100, 16, 1};
        vecs[1] = '{32'h0000_0400, 37, 3};
        vecs[2] = '{32'hFFFF_FFF8,  4, 1};
        vecs[3] = '{32'h0000_2000,  1, 1};
        vecs[4] = '{32'h0000_3000, 33, 3};
        vecs[5] = '{32'h0000_0010, 64, 4};
        vecs[6] = '{32'hFFFF_FFC0, 20, 2};
        vecs[7] = '{32'h0000_5000, 17, 2};

        // Reset state, sampled while reset is held and after release.
        repeat (3) @(negedge clk);
        check("rst_bus", {wb.cyc, wb.stb, wb.cti}, 32'd0);
        check("rst_adr", wb.adr, 32'd0);
        check("rst_out", {busy, done, dout_valid}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_out", {wb.cyc, busy, done, dout_valid}, 32'd0);
        check("dat_ms", wb.dat_ms, 32'd0);

        ready_mode = 2;
        foreach (vecs[i]) begin
            ready_mode = (i % 2 == 0) ? 2 : 0;
            run_xfer($sformatf("vec%0d", i), vecs[i].base, vecs[i].n, vecs[i].nbursts);
        end

        // Zero-length command: done next cycle, no bus activity.
        bursts = 0;
        dones  = 0;
        pulse_start(32'h0000_0500, 0);
        @(negedge clk);
        check("zero_done", {31'b0, done}, 32'd1);
        check("zero_busy", {31'b0, busy}, 32'd0);
        @(negedge clk);
        check("zero_done_pulse", {31'b0, done}, 32'd0);
        repeat (5) @(negedge clk);
        check("zero_bursts", 32'(bursts), 32'd0);
        $display("xfer zero n=0 dones=%0d", dones);

        // Start while busy is ignored.
        ready_mode = 0;
        bursts = 0;
        dones  = 0;
        expect_xfer(32'h0000_1000, 20);
        pulse_start(32'h0000_1000, 20);
        pulse_start(32'h0000_9000, 5);
        @(negedge clk);
        check("busy_held", {31'b0, busy}, 32'd1);
        wait_done("ignore");
        wait_drain("ignore");
        repeat (10) @(negedge clk);
        check("ignore_dones", 32'(dones), 32'd1);
        check("ignore_bursts", 32'(bursts), 32'd2);
        check("ignore_idle", {31'b0, busy}, 32'd0);
        $display("xfer ignore_busy_start dones=%0d bursts=%0d", dones, bursts);

        // Back-pressure: FIFO fills after two bursts and the FSM parks.
        ready_mode = 1;
        bursts = 0;
        dones  = 0;
        expect_xfer(32'h0000_0800, 64);
        pulse_start(32'h0000_0800, 64);
        repeat (300) @(negedge clk);
        check("bp_bursts", 32'(bursts), 32'd2);
        check("bp_parked", {29'b0, wb.cyc, busy, dout_valid}, 32'b011);
        check("bp_beats_left", 32'(exp_adr.size()), 32'd32);
        ready_mode = 0;
        wait_done("bp");
        wait_drain("bp");
        check("bp_bursts_total", 32'(bursts), 32'd4);
        check("bp_dones", 32'(dones), 32'd1);
        $display("xfer backpressure n=64 bursts=%0d", bursts);

        // Reset in the middle of a burst, then a fresh single-word read.
        ready_mode = 2;
        bursts = 0;
        dones  = 0;
        expect_xfer(32'h0000_0600, 16);
        pulse_start(32'h0000_0600, 16);
        begin
            int c = 0;
            while (exp_adr.size() > 11 && c < 500) begin
                @(posedge clk);
                c++;
            end
            if (exp_adr.size() > 11)
                flag_fail("midrst_timeout");
        end
        #2 rst = 1'b1;
        #1;
        check("midrst_bus", {wb.cyc, wb.stb, wb.cti}, 32'd0);
        check("midrst_out", {busy, done, dout_valid}, 32'd0);
        check("midrst_adr", wb.adr, 32'd0);
        exp_adr.delete();
        exp_cti.delete();
        exp_data.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        $display("xfer reset_mid_burst");
        run_xfer("after_rst", 32'h0000_0200, 1, 1);

        // Randomized transfers.
        for (int r = 0; r < 6; r++) begin
            logic [31:0] b;
            int n;
            b = {$urandom(), 2'b00} >> 0;
            b[1:0] = 2'b00;
            n = $urandom_range(1, 50);
            ready_mode = $urandom_range(0, 2) == 1 ? 0 : 2 * (r % 2);
            run_xfer($sformatf("rand%0d", r), b, n, (n + BURST_LEN - 1) / BURST_LEN);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end
endmodule
